// File: rtl/cache_set_engine.sv
// cache_set_engine
// Single-level set-associative tag engine. One access is accepted per
// handshake and walks IDLE -> LOOKUP -> UPDATE -> RESP. Each set is kept as
// an ordered list where way 0 is the most recent (LRU) or newest (FIFO) line.
// Statistics counters saturate at all-ones.
// Optional feature: define CACHE_DIRTY_EN to add per-way dirty bits,
// resp_writeback and the writebacks counter. When it is undefined, both
// outputs are tied to zero. The port list is the same in both builds.
module cache_set_engine #(
  parameter int ADDR_W      = 48,
  parameter int BLOCKSIZE   = 64,
  parameter int NUMSETS     = 64,
  parameter int ASSOC       = 4,
  parameter int REPL_POLICY = 0,
  parameter int CNT_W       = 18,
  localparam int OFF_W      = $clog2(BLOCKSIZE),
  localparam int IDX_W      = $clog2(NUMSETS),
  localparam int TAG_W      = ADDR_W - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic              write_policy,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_evict,
  output logic [TAG_W-1:0]  resp_evict_tag,
  output logic              resp_writeback,
  output logic [CNT_W-1:0]  reads,
  output logic [CNT_W-1:0]  writes,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses,
  output logic [CNT_W-1:0]  writebacks
);

  localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    UPDATE,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic   accept;

  // Captured request
  logic [TAG_W-1:0] reqTag_q;
  logic [IDX_W-1:0] reqIdx_q;
  logic             reqWrite_q;
  logic             reqPolicy_q;

  // Lookup result
  logic             hit_d, hit_q;
  logic [WAY_W-1:0] hitWay_d, hitWay_q;

  // Tag storage and the view of the indexed set
  logic [TAG_W-1:0] tagMem_q [NUMSETS][ASSOC];
  logic [ASSOC-1:0] validMem_q [NUMSETS];
  logic [TAG_W-1:0] curTag [ASSOC];
  logic [ASSOC-1:0] curValid;
  logic [TAG_W-1:0] newTag [ASSOC];
  logic [ASSOC-1:0] newValid;

  logic             evict;
  logic [TAG_W-1:0] evictTag;
  logic             writeEvent;

  // Response and statistics registers
  logic             respHit_q;
  logic             respEvict_q;
  logic [TAG_W-1:0] respEvictTag_q;
  logic [CNT_W-1:0] reads_q, writes_q, hits_q, misses_q;

  // Block offset bits take no part in the lookup
  generate
    if (OFF_W > 0) begin : g_offset
      logic unusedOffset;
      assign unusedOffset = ^req_addr[OFF_W-1:0];
    end
  endgenerate

  // Increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State register. Reset mid-access drops the access entirely
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs. Each state lasts exactly one cycle
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP:  state_d = UPDATE;
      UPDATE:  state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request fields at accept. The address is ignored afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      reqTag_q    <= '0;
      reqIdx_q    <= '0;
      reqWrite_q  <= 1'b0;
      reqPolicy_q <= 1'b0;
    end else if (accept) begin
      reqTag_q    <= req_addr[ADDR_W-1:OFF_W+IDX_W];
      reqIdx_q    <= req_addr[OFF_W +: IDX_W];
      reqWrite_q  <= req_write;
      reqPolicy_q <= write_policy;
    end
  end

  // Present the indexed set as a flat list of ways
  always_comb begin
    for (int w = 0; w < ASSOC; w++) begin
      curTag[w] = tagMem_q[reqIdx_q][w];
    end
    curValid = validMem_q[reqIdx_q];
  end

  // Tag match. Scanning downwards makes the lowest matching way win
  always_comb begin
    hit_d    = 1'b0;
    hitWay_d = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (curValid[w] && (curTag[w] == reqTag_q)) begin
        hit_d    = 1'b1;
        hitWay_d = WAY_W'(w);
      end
    end
  end

  // Register the lookup result for the update cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q    <= 1'b0;
      hitWay_q <= '0;
    end else if (state_q == LOOKUP) begin
      hit_q    <= hit_d;
      hitWay_q <= hitWay_d;
    end
  end

  // New contents of the set. A miss pushes every way down one place. An LRU
  // hit rotates ways 0..h so the hit line lands in way 0. A FIFO hit keeps the order
  always_comb begin
    for (int w = 0; w < ASSOC; w++) begin
      newTag[w] = curTag[w];
    end
    newValid = curValid;
    if (!hit_q) begin
      for (int w = ASSOC - 1; w > 0; w--) begin
        newTag[w]   = curTag[w-1];
        newValid[w] = curValid[w-1];
      end
      newTag[0]   = reqTag_q;
      newValid[0] = 1'b1;
    end else if (REPL_POLICY == 0) begin
      for (int w = ASSOC - 1; w > 0; w--) begin
        if (w <= int'(hitWay_q)) begin
          newTag[w]   = curTag[w-1];
          newValid[w] = curValid[w-1];
        end
      end
      newTag[0]   = reqTag_q;
      newValid[0] = 1'b1;
    end
  end

  // Only a miss can push a valid line out of the last way
  assign evict      = !hit_q && curValid[ASSOC-1];
  assign evictTag   = evict ? curTag[ASSOC-1] : '0;
  assign writeEvent = reqWrite_q && (!reqPolicy_q || !hit_q);

  // Tag array write. Valid bits guard it, so it needs no reset
  always_ff @(posedge clk) begin
    if (!reset && (state_q == UPDATE)) begin
      for (int w = 0; w < ASSOC; w++) begin
        tagMem_q[reqIdx_q][w] <= newTag[w];
      end
    end
  end

  // Valid bits. These are cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUMSETS; s++) validMem_q[s] <= '0;
    end else if (state_q == UPDATE) begin
      validMem_q[reqIdx_q] <= newValid;
    end
  end

  // Response fields and statistics, all committed in the update cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      respHit_q      <= 1'b0;
      respEvict_q    <= 1'b0;
      respEvictTag_q <= '0;
      reads_q        <= '0;
      writes_q       <= '0;
      hits_q         <= '0;
      misses_q       <= '0;
    end else if (state_q == UPDATE) begin
      respHit_q      <= hit_q;
      respEvict_q    <= evict;
      respEvictTag_q <= evictTag;
      if (!reqWrite_q) reads_q  <= satInc(reads_q);
      if (writeEvent)  writes_q <= satInc(writes_q);
      if (hit_q)       hits_q   <= satInc(hits_q);
      else             misses_q <= satInc(misses_q);
    end
  end

  assign resp_hit       = respHit_q;
  assign resp_evict     = respEvict_q;
  assign resp_evict_tag = respEvictTag_q;
  assign reads          = reads_q;
  assign writes         = writes_q;
  assign hits           = hits_q;
  assign misses         = misses_q;

`ifdef CACHE_DIRTY_EN
  logic [ASSOC-1:0] dirtyMem_q [NUMSETS];
  logic [ASSOC-1:0] curDirty, newDirty;
  logic             setDirty;
  logic             wbEvent;
  logic             respWb_q;
  logic [CNT_W-1:0] writebacks_q;

  assign setDirty = reqWrite_q && reqPolicy_q;
  assign wbEvent  = evict && curDirty[ASSOC-1];

  // Dirty bits follow their tags. A FIFO hit marks the hit way in place
  always_comb begin
    curDirty = dirtyMem_q[reqIdx_q];
    newDirty = curDirty;
    if (!hit_q) begin
      for (int w = ASSOC - 1; w > 0; w--) newDirty[w] = curDirty[w-1];
      newDirty[0] = setDirty;
    end else if (REPL_POLICY == 0) begin
      for (int w = ASSOC - 1; w > 0; w--) begin
        if (w <= int'(hitWay_q)) newDirty[w] = curDirty[w-1];
      end
      newDirty[0] = curDirty[hitWay_q] | setDirty;
    end else begin
      newDirty[hitWay_q] = curDirty[hitWay_q] | setDirty;
    end
  end

  // Dirty array, writeback response and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUMSETS; s++) dirtyMem_q[s] <= '0;
      respWb_q     <= 1'b0;
      writebacks_q <= '0;
    end else if (state_q == UPDATE) begin
      dirtyMem_q[reqIdx_q] <= newDirty;
      respWb_q             <= wbEvent;
      if (wbEvent) writebacks_q <= satInc(writebacks_q);
    end
  end

  assign resp_writeback = respWb_q;
  assign writebacks     = writebacks_q;
`else
  assign resp_writeback = 1'b0;
  assign writebacks     = '0;
`endif

endmodule

// File: tb/tb_cache_set_engine.sv
// tb_cache_set_engine
// Three engines share one stimulus stream: an LRU engine, a FIFO engine,
// and an LRU engine with 2-bit counters. All use NUMSETS=4, ASSOC=2 and
// BLOCKSIZE=16, so index = addr[5:4] and tag = addr[47:6].
// Expectations for resp_writeback and writebacks follow CACHE_DIRTY_EN.
module tb_cache_set_engine;

  localparam int ADDR_W = 48;
  localparam int TAG_W  = 42;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic              write_policy;

  logic              lReady, lValid, lHit, lEvict, lWb;
  logic [TAG_W-1:0]  lEvTag;
  logic [17:0]       lReads, lWrites, lHits, lMisses, lWbs;

  logic              fReady, fValid, fHit, fEvict, fWb;
  logic [TAG_W-1:0]  fEvTag;
  logic [17:0]       fReads, fWrites, fHits, fMisses, fWbs;

  logic              sReady, sValid, sHit, sEvict, sWb;
  logic [TAG_W-1:0]  sEvTag;
  logic [1:0]        sReads, sWrites, sHits, sMisses, sWbs;

  int   compared   = 0;
  int   mismatched = 0;
  int   lat;
  logic busyOk;

  always #5 clk = ~clk;

  cache_set_engine #(.ADDR_W(48), .BLOCKSIZE(16), .NUMSETS(4), .ASSOC(2),
                     .REPL_POLICY(0), .CNT_W(18)) dutLru (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(lReady),
    .req_addr(req_addr), .req_write(req_write), .write_policy(write_policy),
    .resp_valid(lValid), .resp_hit(lHit), .resp_evict(lEvict),
    .resp_evict_tag(lEvTag), .resp_writeback(lWb), .reads(lReads),
    .writes(lWrites), .hits(lHits), .misses(lMisses), .writebacks(lWbs));

  cache_set_engine #(.ADDR_W(48), .BLOCKSIZE(16), .NUMSETS(4), .ASSOC(2),
                     .REPL_POLICY(1), .CNT_W(18)) dutFifo (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(fReady),
    .req_addr(req_addr), .req_write(req_write), .write_policy(write_policy),
    .resp_valid(fValid), .resp_hit(fHit), .resp_evict(fEvict),
    .resp_evict_tag(fEvTag), .resp_writeback(fWb), .reads(fReads),
    .writes(fWrites), .hits(fHits), .misses(fMisses), .writebacks(fWbs));

  cache_set_engine #(.ADDR_W(48), .BLOCKSIZE(16), .NUMSETS(4), .ASSOC(2),
                     .REPL_POLICY(0), .CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(sReady),
    .req_addr(req_addr), .req_write(req_write), .write_policy(write_policy),
    .resp_valid(sValid), .resp_hit(sHit), .resp_evict(sEvict),
    .resp_evict_tag(sEvTag), .resp_writeback(sWb), .reads(sReads),
    .writes(sWrites), .hits(sHits), .misses(sMisses), .writebacks(sWbs));

  task automatic resetDut();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One access, returning the latency in negedges after the accept edge.
  // busyOk stays set only if req_ready stays low until the response strobe.
  // After accept, the request inputs are scrambled, which the engine must ignore.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic wr,
                               input logic wp);
    int guard;
    @(negedge clk);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_write    = wr;
    write_policy = wp;
    guard = 0;
    while (!lReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = '1;
    req_write    = ~wr;
    write_policy = ~wp;
    lat    = 0;
    busyOk = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lReady) busyOk = 1'b0;
    end while (!lValid && lat < 20);
  endtask

  task automatic test_reset();
    resetDut();
    @(negedge clk);
    compared++; if (lReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", lReady); end
    compared++; if (lValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", lValid); end
    compared++; if (lHit !== 1'b0 || lEvict !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_resp: hit %b evict %b expected 0 0", lHit, lEvict); end
    compared++; if (lReads !== 18'd0 || lMisses !== 18'd0 || lHits !== 18'd0 || lWrites !== 18'd0) begin mismatched++; $display("[TB] FAIL reset_counters: r %0d m %0d h %0d w %0d expected all 0", lReads, lMisses, lHits, lWrites); end
  endtask

  task automatic test_first_miss();
    resetDut();
    applyStimulus(48'h000, 1'b0, 1'b0);
    compared++; if (lat !== 3) begin mismatched++; $display("[TB] FAIL latency: got %0d expected 3", lat); end
    compared++; if (busyOk !== 1'b1) begin mismatched++; $display("[TB] FAIL busy_ready: got %b expected 1", busyOk); end
    compared++; if (lHit !== 1'b0 || lEvict !== 1'b0 || lEvTag !== '0) begin mismatched++; $display("[TB] FAIL first_miss_resp: hit %b evict %b tag %h expected 0 0 0", lHit, lEvict, lEvTag); end
    compared++; if (lMisses !== 18'd1 || lReads !== 18'd1 || lHits !== 18'd0) begin mismatched++; $display("[TB] FAIL first_miss_cnt: m %0d r %0d h %0d expected 1 1 0", lMisses, lReads, lHits); end
    @(negedge clk);
    compared++; if (lValid !== 1'b0 || lReady !== 1'b1) begin mismatched++; $display("[TB] FAIL strobe_end: valid %b ready %b expected 0 1", lValid, lReady); end
  endtask

  task automatic test_hit_tag0();
    resetDut();
    applyStimulus(48'h000, 1'b0, 1'b0);
    applyStimulus(48'h000, 1'b0, 1'b0);
    compared++; if (lHit !== 1'b1) begin mismatched++; $display("[TB] FAIL tag0_hit: got %b expected 1", lHit); end
    compared++; if (lHits !== 18'd1 || lMisses !== 18'd1 || lReads !== 18'd2) begin mismatched++; $display("[TB] FAIL tag0_cnt: h %0d m %0d r %0d expected 1 1 2", lHits, lMisses, lReads); end
  endtask

  task automatic test_replacement();
    resetDut();
    applyStimulus(48'h000, 1'b0, 1'b0);
    applyStimulus(48'h040, 1'b0, 1'b0);
    applyStimulus(48'h000, 1'b0, 1'b0);
    compared++; if (lHit !== 1'b1 || fHit !== 1'b1) begin mismatched++; $display("[TB] FAIL repl_hit: lru %b fifo %b expected 1 1", lHit, fHit); end
    applyStimulus(48'h080, 1'b0, 1'b0);
    compared++; if (lHit !== 1'b0 || lEvict !== 1'b1 || lEvTag !== 42'd1) begin mismatched++; $display("[TB] FAIL lru_evict: hit %b evict %b tag %h expected 0 1 1", lHit, lEvict, lEvTag); end
    compared++; if (fHit !== 1'b0 || fEvict !== 1'b1 || fEvTag !== 42'd0) begin mismatched++; $display("[TB] FAIL fifo_evict: hit %b evict %b tag %h expected 0 1 0", fHit, fEvict, fEvTag); end
    compared++; if (lHits !== 18'd1 || lMisses !== 18'd3) begin mismatched++; $display("[TB] FAIL repl_cnt: h %0d m %0d expected 1 3", lHits, lMisses); end
    repeat (3) @(negedge clk);
    compared++; if (lEvTag !== 42'd1 || lEvict !== 1'b1) begin mismatched++; $display("[TB] FAIL resp_hold: evict %b tag %h expected 1 1", lEvict, lEvTag); end
  endtask

  task automatic test_writes();
    resetDut();
    applyStimulus(48'h100, 1'b1, 1'b0);
    applyStimulus(48'h100, 1'b1, 1'b0);
    compared++; if (lWrites !== 18'd2 || lReads !== 18'd0 || lHit !== 1'b1) begin mismatched++; $display("[TB] FAIL write_through: w %0d r %0d hit %b expected 2 0 1", lWrites, lReads, lHit); end
    resetDut();
    applyStimulus(48'h100, 1'b1, 1'b1);
    applyStimulus(48'h100, 1'b1, 1'b1);
    compared++; if (lWrites !== 18'd1 || lHits !== 18'd1) begin mismatched++; $display("[TB] FAIL write_back: w %0d h %0d expected 1 1", lWrites, lHits); end
  endtask

  task automatic test_saturation();
    logic [ADDR_W-1:0] addrs [5];
    addrs = '{48'h000, 48'h040, 48'h080, 48'h0C0, 48'h100};
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(addrs[i], 1'b0, 1'b0);
    compared++; if (sMisses !== 2'd3 || sReads !== 2'd3) begin mismatched++; $display("[TB] FAIL saturate: m %0d r %0d expected 3 3", sMisses, sReads); end
    compared++; if (lMisses !== 18'd5) begin mismatched++; $display("[TB] FAIL wide_misses: got %0d expected 5", lMisses); end
    compared++; if (lEvTag !== 42'd2) begin mismatched++; $display("[TB] FAIL sat_evict_tag: got %h expected 2", lEvTag); end
  endtask

  task automatic test_reset_mid();
    logic sawResp;
    resetDut();
    applyStimulus(48'h040, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 48'h000;
    req_write = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    sawResp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (lValid) sawResp = 1'b1;
    end
    reset = 1'b0;
    compared++; if (sawResp !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_resp: got %b expected 0", sawResp); end
    compared++; if (lMisses !== 18'd0 || lReads !== 18'd0) begin mismatched++; $display("[TB] FAIL abort_cnt: m %0d r %0d expected 0 0", lMisses, lReads); end
    applyStimulus(48'h000, 1'b0, 1'b0);
    compared++; if (lHit !== 1'b0 || lMisses !== 18'd1 || lEvict !== 1'b0) begin mismatched++; $display("[TB] FAIL replay: hit %b m %0d evict %b expected 0 1 0", lHit, lMisses, lEvict); end
  endtask

  task automatic test_dirty();
    logic expWb;
`ifdef CACHE_DIRTY_EN
    expWb = 1'b1;
`else
    expWb = 1'b0;
`endif
    resetDut();
    applyStimulus(48'h000, 1'b1, 1'b1);
    applyStimulus(48'h040, 1'b0, 1'b0);
    compared++; if (lWb !== 1'b0) begin mismatched++; $display("[TB] FAIL no_wb_yet: got %b expected 0", lWb); end
    applyStimulus(48'h080, 1'b0, 1'b0);
    compared++; if (lEvict !== 1'b1 || lEvTag !== 42'd0) begin mismatched++; $display("[TB] FAIL dirty_evict: evict %b tag %h expected 1 0", lEvict, lEvTag); end
    compared++; if (lWb !== expWb || lWbs !== 18'(expWb)) begin mismatched++; $display("[TB] FAIL writeback: wb %b cnt %0d expected %b %0d", lWb, lWbs, expWb, expWb); end
    compared++; if (lWrites !== 18'd1) begin mismatched++; $display("[TB] FAIL dirty_writes: got %0d expected 1", lWrites); end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_write    = 1'b0;
    write_policy = 1'b0;
    test_reset();
    test_first_miss();
    test_hit_tag0();
    test_replacement();
    test_writes();
    test_saturation();
    test_reset_mid();
    test_dirty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
